// File: rtl/dec_value_entry_pkg.sv
// Shared types for the decimal value entry block.
// States, BCD digit type and digit bound.
package dec_value_entry_pkg;

  typedef enum logic [1:0] {
    DE_IDLE,
    DE_EDIT,
    DE_CONVERT
  } DEC_ENTRY_STATE;

  typedef logic [3:0] t_BCD_DIGIT;

  localparam t_BCD_DIGIT BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/dec_value_entry_bcd_mac_step.sv
// One decimal accumulate step: acc*10 + d.
// Saturates at all-ones instead of wrapping.
module bcd_mac_step
  import dec_value_entry_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [AW-1:0] acc_i,
  input  t_BCD_DIGIT    d_i,
  output logic [AW-1:0] acc_o
);

  logic [AW+3:0] ext;
  logic [AW+3:0] wide;

  // x10 as x8 + x2, plus the digit, with 4 guard bits for overflow
  always_comb begin
    ext  = {4'b0000, acc_i};
    wide = (ext << 3) + (ext << 1) + {{AW{1'b0}}, d_i};
    if (|wide[AW+3:AW]) begin
      acc_o = '1;
    end else begin
      acc_o = wide[AW-1:0];
    end
  end

endmodule

// File: rtl/dec_value_entry.sv
// Decimal digit entry: BCD edit buffer to clamped binary value.
// Conversion runs one digit per cycle, most significant first.
module dec_value_entry
  import dec_value_entry_pkg::*;
#(
  parameter int               W_OUT   = 8,
  parameter int               LEN     = 2,
  parameter logic [W_OUT-1:0] MIN_VAL = W_OUT'(1),
  parameter logic [W_OUT-1:0] MAX_VAL = W_OUT'(99)
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      start,
  input  logic                      digit_valid,
  input  logic [3:0]                digit,
  input  logic                      backspace,
  input  logic                      enter,
  input  logic                      cancel,
  output logic                      editing,
  output logic                      busy,
  output logic [LEN-1:0][3:0]       digits,
  output logic [2:0]                digit_count,
  output logic [W_OUT-1:0]          value,
  output logic                      value_valid,
  output logic                      clamped,
  output logic                      cancelled
);

  localparam int AW = W_OUT + 4;
  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [2:0] LEN3 = 3'(LEN);
  localparam logic [AW-1:0] MIN_EXT = AW'(MIN_VAL);
  localparam logic [AW-1:0] MAX_EXT = AW'(MAX_VAL);

  DEC_ENTRY_STATE state_q, state_d;
  t_BCD_DIGIT [LEN-1:0] digits_q, digits_d;
  logic [2:0] cnt_q, cnt_d;
  logic [W_OUT-1:0] value_q, value_d;
  logic clamped_q, clamped_d;
  logic vv_q, vv_d;
  logic canc_q, canc_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] mac_out;

  bcd_mac_step #(
    .AW(AW)
  ) u_mac (
    .acc_i(acc_q),
    .d_i  (digits_q[idx_q]),
    .acc_o(mac_out)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= DE_IDLE;
      digits_q  <= '0;
      cnt_q     <= '0;
      value_q   <= MIN_VAL;
      clamped_q <= 1'b0;
      vv_q      <= 1'b0;
      canc_q    <= 1'b0;
      acc_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      clamped_q <= clamped_d;
      vv_q      <= vv_d;
      canc_q    <= canc_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
    end
  end

  // Next state: prioritised edit events, then one MAC step per cycle
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    clamped_d = clamped_q;
    vv_d      = 1'b0;
    canc_d    = 1'b0;
    acc_d     = acc_q;
    idx_d     = idx_q;
    unique case (state_q)
      DE_IDLE: begin
        if (start) begin
          state_d  = DE_EDIT;
          digits_d = '0;
          cnt_d    = '0;
        end
      end
      DE_EDIT: begin
        if (cancel || (enter && cnt_q == 3'd0)) begin
          state_d = DE_IDLE;
          canc_d  = 1'b1;
        end else if (enter) begin
          state_d = DE_CONVERT;
          acc_d   = '0;
          idx_d   = IW'(cnt_q - 3'd1);
        end else if (backspace) begin
          if (cnt_q != 3'd0) begin
            for (int k = 0; k < LEN - 1; k++) begin
              digits_d[k] = digits_q[k+1];
            end
            digits_d[LEN-1] = '0;
            cnt_d = cnt_q - 3'd1;
          end
        end else if (digit_valid) begin
          if (digit <= BCD_MAX_DIGIT && cnt_q < LEN3) begin
            for (int k = 1; k < LEN; k++) begin
              digits_d[k] = digits_q[k-1];
            end
            digits_d[0] = digit;
            cnt_d = cnt_q + 3'd1;
          end
        end else if (start) begin
          digits_d = '0;
          cnt_d    = '0;
        end
      end
      DE_CONVERT: begin
        acc_d = mac_out;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d = DE_IDLE;
          vv_d    = 1'b1;
          if (mac_out < MIN_EXT) begin
            value_d   = MIN_VAL;
            clamped_d = 1'b1;
          end else if (mac_out > MAX_EXT) begin
            value_d   = MAX_VAL;
            clamped_d = 1'b1;
          end else begin
            value_d   = mac_out[W_OUT-1:0];
            clamped_d = 1'b0;
          end
        end
      end
      default: state_d = DE_IDLE;
    endcase
  end

  assign editing     = (state_q == DE_EDIT);
  assign busy        = (state_q == DE_CONVERT);
  assign digits      = digits_q;
  assign digit_count = cnt_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign clamped     = clamped_q;
  assign cancelled   = canc_q;

endmodule

// File: tb/tb_dec_value_entry.sv
// Bench for dec_value_entry: two configurations, one shared
// stimulus stream, behavioural model plus literal checks.
module tb_dec_value_entry;

  logic clk;
  logic nrst;
  logic start;
  logic digit_valid;
  logic [3:0] digit;
  logic backspace;
  logic enter;
  logic cancel;

  logic a_ed, a_busy, a_vv, a_cl, a_cn;
  logic [1:0][3:0] a_dig;
  logic [2:0] a_cnt;
  logic [7:0] a_val;

  logic b_ed, b_busy, b_vv, b_cl, b_cn;
  logic [1:0][3:0] b_dig;
  logic [2:0] b_cnt;
  logic [4:0] b_val;

  int vectors = 0;
  int miscompares = 0;

  // model state, index 0 = config A, 1 = config B
  int m_state[2];
  int m_dig[2][2];
  int m_cnt[2];
  int m_val[2];
  int m_clamp[2];
  int m_vv[2];
  int m_canc[2];
  int m_left[2];
  int c_max[2] = '{99, 20};
  int c_sat[2] = '{4095, 511};

  dec_value_entry #(
    .W_OUT(8), .LEN(2), .MIN_VAL(8'd1), .MAX_VAL(8'd99)
  ) dut_a (
    .clk(clk), .nrst(nrst), .start(start),
    .digit_valid(digit_valid), .digit(digit),
    .backspace(backspace), .enter(enter), .cancel(cancel),
    .editing(a_ed), .busy(a_busy), .digits(a_dig),
    .digit_count(a_cnt), .value(a_val), .value_valid(a_vv),
    .clamped(a_cl), .cancelled(a_cn)
  );

  dec_value_entry #(
    .W_OUT(5), .LEN(2), .MIN_VAL(5'd1), .MAX_VAL(5'd20)
  ) dut_b (
    .clk(clk), .nrst(nrst), .start(start),
    .digit_valid(digit_valid), .digit(digit),
    .backspace(backspace), .enter(enter), .cancel(cancel),
    .editing(b_ed), .busy(b_busy), .digits(b_dig),
    .digit_count(b_cnt), .value(b_val), .value_valid(b_vv),
    .clamped(b_cl), .cancelled(b_cn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // what the next rising edge does, per the behavioural rules
  task automatic model_step();
    int num;
    for (int c = 0; c < 2; c++) begin
      if (!nrst) begin
        m_state[c] = 0;
        m_dig[c][0] = 0;
        m_dig[c][1] = 0;
        m_cnt[c] = 0;
        m_val[c] = 1;
        m_clamp[c] = 0;
        m_vv[c] = 0;
        m_canc[c] = 0;
        m_left[c] = 0;
      end else begin
        m_vv[c] = 0;
        m_canc[c] = 0;
        case (m_state[c])
          0: if (start) begin
            m_state[c] = 1;
            m_dig[c][0] = 0;
            m_dig[c][1] = 0;
            m_cnt[c] = 0;
          end
          1: begin
            if (cancel || (enter && m_cnt[c] == 0)) begin
              m_state[c] = 0;
              m_canc[c] = 1;
            end else if (enter) begin
              m_state[c] = 2;
              m_left[c] = m_cnt[c];
            end else if (backspace) begin
              if (m_cnt[c] > 0) begin
                m_dig[c][0] = m_dig[c][1];
                m_dig[c][1] = 0;
                m_cnt[c]--;
              end
            end else if (digit_valid) begin
              if (digit <= 9 && m_cnt[c] < 2) begin
                m_dig[c][1] = m_dig[c][0];
                m_dig[c][0] = int'(digit);
                m_cnt[c]++;
              end
            end else if (start) begin
              m_dig[c][0] = 0;
              m_dig[c][1] = 0;
              m_cnt[c] = 0;
            end
          end
          default: begin
            m_left[c]--;
            if (m_left[c] == 0) begin
              num = 0;
              for (int i = 0; i < m_cnt[c]; i++)
                num += m_dig[c][i] * (10 ** i);
              if (num > c_sat[c]) num = c_sat[c];
              if (num < 1) begin
                m_val[c] = 1;
                m_clamp[c] = 1;
              end else if (num > c_max[c]) begin
                m_val[c] = c_max[c];
                m_clamp[c] = 1;
              end else begin
                m_val[c] = num;
                m_clamp[c] = 0;
              end
              m_vv[c] = 1;
              m_state[c] = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic cmp_one(input string p, input int c,
                         input logic ed, input logic bz,
                         input logic [2:0] cnt,
                         input logic [3:0] d0, input logic [3:0] d1,
                         input logic [7:0] val, input logic cl,
                         input logic vv, input logic cn);
    chk({p, ".editing"}, 32'(ed), 32'(m_state[c] == 1));
    chk({p, ".busy"}, 32'(bz), 32'(m_state[c] == 2));
    chk({p, ".digit_count"}, 32'(cnt), m_cnt[c]);
    chk({p, ".digits0"}, 32'(d0), m_dig[c][0]);
    chk({p, ".digits1"}, 32'(d1), m_dig[c][1]);
    chk({p, ".value"}, 32'(val), m_val[c]);
    chk({p, ".clamped"}, 32'(cl), m_clamp[c]);
    chk({p, ".value_valid"}, 32'(vv), m_vv[c]);
    chk({p, ".cancelled"}, 32'(cn), m_canc[c]);
    if (vv && cn) chk({p, ".pulse_overlap"}, 32'(1), 32'(0));
  endtask

  task automatic compare_all();
    cmp_one("a", 0, a_ed, a_busy, a_cnt, a_dig[0], a_dig[1],
            a_val, a_cl, a_vv, a_cn);
    cmp_one("b", 1, b_ed, b_busy, b_cnt, b_dig[0], b_dig[1],
            {3'b000, b_val}, b_cl, b_vv, b_cn);
  endtask

  // apply one cycle of inputs, advance model and DUT, compare
  task automatic ev(input logic i_st, input logic i_dv,
                    input logic [3:0] i_d, input logic i_bs,
                    input logic i_en, input logic i_cn);
    start = i_st;
    digit_valid = i_dv;
    digit = i_d;
    backspace = i_bs;
    enter = i_en;
    cancel = i_cn;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    ev(0, 0, 4'd0, 0, 0, 0);
  endtask

  task automatic key(input logic [3:0] d);
    ev(0, 1, d, 0, 0, 0);
  endtask

  initial begin
    nrst = 1'b0;
    start = 0; digit_valid = 0; digit = 0;
    backspace = 0; enter = 0; cancel = 0;
    @(negedge clk);
    idle();
    chk("lit.reset.value", 32'(a_val), 32'd1);
    chk("lit.reset.count", 32'(a_cnt), 32'd0);
    chk("lit.reset.editing", 32'(a_ed), 32'd0);
    nrst = 1'b1;

    // basic commit: 1,2 -> 12, pulse after enter edge + 2
    ev(1, 0, 0, 0, 0, 0);
    key(4'd1);
    key(4'd2);
    ev(0, 0, 0, 0, 1, 0);
    idle();
    chk("lit.basic.early_pulse", 32'(a_vv), 32'd0);
    idle();
    chk("lit.basic.vv", 32'(a_vv), 32'd1);
    chk("lit.basic.value", 32'(a_val), 32'd12);
    chk("lit.basic.clamped", 32'(a_cl), 32'd0);
    chk("lit.basic.digits", 32'(a_dig), 32'h12);
    idle();
    chk("lit.basic.vv_gone", 32'(a_vv), 32'd0);

    // full buffer: 9,9,7 -> 7 ignored
    ev(1, 0, 0, 0, 0, 0);
    key(4'd9);
    key(4'd9);
    key(4'd7);
    chk("lit.full.count", 32'(a_cnt), 32'd2);
    ev(0, 0, 0, 0, 1, 0);
    idle();
    idle();
    chk("lit.full.value", 32'(a_val), 32'd99);
    chk("lit.full.b_value", 32'(b_val), 32'd20);
    chk("lit.full.b_clamped", 32'(b_cl), 32'd1);

    // edit then clamp low: 4, bs, bs, 0 -> 0 -> MIN
    ev(1, 0, 0, 0, 0, 0);
    key(4'd4);
    ev(0, 0, 0, 1, 0, 0);
    ev(0, 0, 0, 1, 0, 0);
    key(4'd0);
    ev(0, 0, 0, 0, 1, 0);
    idle();
    chk("lit.low.vv", 32'(a_vv), 32'd1);
    chk("lit.low.value", 32'(a_val), 32'd1);
    chk("lit.low.clamped", 32'(a_cl), 32'd1);

    // clamp high on the narrow config: 35 -> 20
    ev(1, 0, 0, 0, 0, 0);
    key(4'd3);
    key(4'd5);
    ev(0, 0, 0, 0, 1, 0);
    idle();
    idle();
    chk("lit.high.b_value", 32'(b_val), 32'd20);
    chk("lit.high.b_clamped", 32'(b_cl), 32'd1);
    chk("lit.high.a_value", 32'(a_val), 32'd35);

    // enter wins over a same-cycle digit
    ev(1, 0, 0, 0, 0, 0);
    key(4'd7);
    ev(0, 1, 4'd5, 0, 1, 0);
    idle();
    chk("lit.simul.value", 32'(a_val), 32'd7);

    // cancel wins over enter
    ev(1, 0, 0, 0, 0, 0);
    key(4'd3);
    ev(0, 0, 0, 0, 1, 1);
    chk("lit.cancel.pulse", 32'(a_cn), 32'd1);
    chk("lit.cancel.value", 32'(a_val), 32'd7);
    idle();

    // enter on empty buffer aborts
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 0, 0, 0, 1, 0);
    chk("lit.empty.cancel", 32'(a_cn), 32'd1);
    chk("lit.empty.vv", 32'(a_vv), 32'd0);

    // reset during conversion
    ev(1, 0, 0, 0, 0, 0);
    key(4'd4);
    key(4'd2);
    ev(0, 0, 0, 0, 1, 0);
    nrst = 1'b0;
    idle();
    nrst = 1'b1;
    chk("lit.rst.busy", 32'(a_busy), 32'd0);
    chk("lit.rst.value", 32'(a_val), 32'd1);
    chk("lit.rst.count", 32'(a_cnt), 32'd0);
    idle();
    chk("lit.rst.vv", 32'(a_vv), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      nrst = ($urandom_range(0, 199) != 0);
      ev($urandom_range(0, 7) == 0,
         $urandom_range(0, 2) == 0,
         4'($urandom_range(0, 11)),
         $urandom_range(0, 7) == 0,
         $urandom_range(0, 7) == 0,
         $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dec_value_entry.md
Name: dec_value_entry

Overview:
- Inverse of the options decimalizer. It collects decimal digit key events into a BCD edit buffer and converts the buffer to a binary option value using a sequential multiply-by-10-and-add.
- It clamps the result to [MIN_VAL, MAX_VAL] and emits a one-cycle commit pulse.
- It sits between the input/keyboard decoder and the options register file (pin_colors, pins_count, guesses, PIX_W, PIX_H).
- The BCD buffer is exported with the same digit ordering as st_GS_DECIMALIZED (index 0 = ones), so the options renderer can draw the value while it is being edited.

Parameters:
- W_OUT, 8: width of the binary result.
- LEN, 2: maximum digits in the buffer (1..4).
- MIN_VAL, 1: lower clamp bound (W_OUT bits).
- MAX_VAL, 99: upper clamp bound (W_OUT bits); must satisfy MIN_VAL <= MAX_VAL < 2**W_OUT.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, synchronous, active-low.
- start  in  1  begin an edit session; clears the buffer.
- digit_valid  in  1  digit key event strobe.
- digit  in  4  digit value; values above 9 are ignored.
- backspace  in  1  delete the newest digit.
- enter  in  1  commit the buffer.
- cancel  in  1  abort the edit.
- editing  out  1  high in the EDIT state.
- busy  out  1  high in the CONVERT state.
- digits  out  [LEN-1:0][3:0]  BCD buffer, [0] = newest/ones digit.
- digit_count  out  3  number of valid digits, 0..LEN.
- value  out  W_OUT  last committed value, held between commits.
- value_valid  out  1  one-cycle commit pulse.
- clamped  out  1  the committed value was clamped; valid with value_valid and held until the next commit.
- cancelled  out  1  one-cycle abort pulse.

Behaviour:
- Reset (one clock only; nrst is sampled on the rising edge): state = IDLE, digits = 0, digit_count = 0, value = MIN_VAL, clamped = 0. editing, busy, value_valid and cancelled are all 0.
- States: IDLE, EDIT, CONVERT.
- IDLE:
  - start -> EDIT, with digits = 0 and digit_count = 0.
  - All other inputs are ignored.
- EDIT: per cycle, at most one event is taken, in priority order cancel > enter > backspace > digit_valid.
  - cancel -> IDLE; cancelled pulses next cycle; buffer retained; value unchanged.
  - enter with digit_count = 0 -> treated exactly as cancel.
  - enter with digit_count > 0 -> CONVERT; accumulator = 0; index = digit_count - 1.
  - backspace with digit_count > 0:
    - digits[k] = digits[k+1] for k < LEN-1;
    - digits[LEN-1] = 0;
    - digit_count decrements.
  - backspace with digit_count = 0 -> no-op.
  - digit_valid with digit <= 9 and digit_count < LEN:
    - digits[k] = digits[k-1] for k > 0;
    - digits[0] = digit;
    - digit_count increments.
  - digit_valid when the buffer is full (digit_count = LEN) or digit > 9 -> ignored; no overwrite.
  - start -> re-clears the buffer and stays in EDIT. start has lowest priority among the events.
- CONVERT:
  - Each cycle: acc = acc*10 + digits[index], then index decrements. Multiply is (acc<<3)+(acc<<1).
  - The accumulator is W_OUT+4 bits wide and saturates at all-ones; it never wraps.
  - Conversion takes digit_count cycles. All inputs, including start, are ignored here.
  - After the final step:
    - value = clamp(acc) (written with MIN_VAL if acc < MIN_VAL, MAX_VAL if acc > MAX_VAL);
    - clamped = 1 if either bound applied, else 0;
    - value_valid pulses;
    - state -> IDLE.
  - The buffer is left intact for display.
- Latency: if enter is sampled at edge E with N digits, value_valid is high in the cycle following edge E+N.
  - Example, N = 2: pulse visible after edge E+2, i.e. 3 cycles after the enter cycle.
- Pulse rules: value_valid and cancelled are never high together and never last longer than one cycle.
- Reset mid-CONVERT aborts the conversion: no value_valid, value returns to MIN_VAL.

Decomposition:
- Shared package gets:
  - DEC_ENTRY_STATE enum {DE_IDLE, DE_EDIT, DE_CONVERT};
  - t_BCD_DIGIT typedef (logic [3:0]);
  - constant BCD_MAX_DIGIT = 4'd9.
- One combinational sub-module, bcd_mac_step:
  - computes acc*10 + d with saturation at the accumulator width;
  - is instantiated once and reused across the CONVERT cycles.

Test Plan:
- Basic commit (LEN=2): start; digit 1; digit 2; enter -> value_valid high in the 3rd cycle after enter, value = 12, clamped = 0, state IDLE, digits = {1,2}.
- Full buffer: start; digits 9, 9, 7; enter -> 7 ignored, digit_count = 2, value = 99, clamped = 0.
- Edit and clamp low: start; digit 4; backspace; backspace (second one is a no-op); digit 0; enter -> value = 1 (MIN_VAL), clamped = 1.
- Clamp high (W_OUT=5, MAX_VAL=20): start; digits 3, 5; enter -> value = 20, clamped = 1.
- Simultaneous events and abort:
  - enter + digit 5 in the same cycle with buffer {7} -> commit value = 7, digit 5 dropped.
  - cancel + enter in the same cycle -> cancelled pulse, value unchanged.
  - enter on an empty buffer -> cancelled pulse, no value_valid.
- Reset mid-operation: nrst low for one cycle during CONVERT -> next cycle state IDLE, value = MIN_VAL, digit_count = 0, no value_valid pulse.
